// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - staged reset-release controller with soft reset, watchdog and cause capture
module rst_sequencer #(
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4,
    parameter int WDT_CYCLES  = 1024
) (
    input  logic                  clk_sys,
    input  logic                  rst,
    input  logic                  soft_rst_req,
    input  logic                  wdt_en,
    input  logic                  wdt_kick,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  rst_done,
    output logic [1:0]            rst_cause
);
    localparam int MAX_A = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int MAXC  = (MAX_A > WDT_CYCLES) ? MAX_A : WDT_CYCLES;
    localparam int CW    = (MAXC > 2) ? $clog2(MAXC) : 1;
    localparam int SW    = $clog2(NUM_STAGES + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] WDT_LAST  = CW'(WDT_CYCLES - 1);
    localparam logic [SW-1:0] STG_LAST  = SW'(NUM_STAGES - 1);

    localparam logic [1:0] CAUSE_POR  = 2'b01;
    localparam logic [1:0] CAUSE_SOFT = 2'b10;
    localparam logic [1:0] CAUSE_WDT  = 2'b11;

    typedef enum logic [1:0] {
        S_ASSERT  = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic [SW-1:0]         r_stage, w_stage_nxt;
    logic [CW-1:0]         r_wdt_cnt, w_wdt_cnt_nxt;
    logic [NUM_STAGES-1:0] r_rst_out, w_rst_out_nxt;
    logic                  r_rst_done, w_rst_done_nxt;
    logic [1:0]            r_rst_cause, w_rst_cause_nxt;
    logic                  w_timeout;

    // A kick in the terminal cycle suppresses the timeout.
    assign w_timeout = (r_state == S_RUN) && wdt_en && !wdt_kick && (r_wdt_cnt == WDT_LAST);

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_state     <= S_ASSERT;
            r_cnt       <= '0;
            r_stage     <= '0;
            r_wdt_cnt   <= '0;
            r_rst_out   <= '1;
            r_rst_done  <= 1'b0;
            r_rst_cause <= CAUSE_POR;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_stage     <= w_stage_nxt;
            r_wdt_cnt   <= w_wdt_cnt_nxt;
            r_rst_out   <= w_rst_out_nxt;
            r_rst_done  <= w_rst_done_nxt;
            r_rst_cause <= w_rst_cause_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_stage_nxt     = r_stage;
        w_wdt_cnt_nxt   = '0;
        w_rst_out_nxt   = r_rst_out;
        w_rst_done_nxt  = r_rst_done;
        w_rst_cause_nxt = r_rst_cause;

        if (soft_rst_req || w_timeout) begin
            w_state_nxt     = S_ASSERT;
            w_cnt_nxt       = '0;
            w_stage_nxt     = '0;
            w_rst_out_nxt   = '1;
            w_rst_done_nxt  = 1'b0;
            w_rst_cause_nxt = soft_rst_req ? CAUSE_SOFT : CAUSE_WDT;
        end else begin
            case (r_state)
                S_ASSERT: begin
                    w_rst_out_nxt = '1;
                    if (r_cnt == HOLD_LAST) begin
                        w_cnt_nxt        = '0;
                        w_rst_out_nxt[0] = 1'b0;
                        if (NUM_STAGES == 1) begin
                            w_state_nxt    = S_RUN;
                            w_rst_done_nxt = 1'b1;
                        end else begin
                            w_stage_nxt = SW'(1);
                            w_state_nxt = S_RELEASE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (r_cnt == GAP_LAST) begin
                        w_cnt_nxt     = '0;
                        w_rst_out_nxt = r_rst_out & ~(NUM_STAGES'(1) << r_stage);
                        w_stage_nxt   = r_stage + 1'b1;
                        if (r_stage == STG_LAST) begin
                            w_state_nxt    = S_RUN;
                            w_rst_done_nxt = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    w_rst_out_nxt  = '0;
                    w_rst_done_nxt = 1'b1;
                    if (wdt_en && !wdt_kick) begin
                        w_wdt_cnt_nxt = r_wdt_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt     = S_ASSERT;
                    w_cnt_nxt       = '0;
                    w_stage_nxt     = '0;
                    w_rst_out_nxt   = '1;
                    w_rst_done_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign rst_out   = r_rst_out;
    assign rst_done  = r_rst_done;
    assign rst_cause = r_rst_cause;
endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - directed self-checking bench for rst_sequencer
module tb_rst_sequencer;
    logic       clk_sys = 1'b0;
    logic       rst = 1'b1;
    logic       soft_rst_req = 1'b0;
    logic       wdt_en = 1'b0;
    logic       wdt_kick = 1'b0;
    logic [2:0] rst_out;
    logic       rst_done;
    logic [1:0] rst_cause;

    int checks = 0;
    int failures = 0;

    always #5 clk_sys = ~clk_sys;

    rst_sequencer #(
        .NUM_STAGES (3),
        .HOLD_CYCLES(16),
        .STAGE_GAP  (4),
        .WDT_CYCLES (8)
    ) dut (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .soft_rst_req(soft_rst_req),
        .wdt_en      (wdt_en),
        .wdt_kick    (wdt_kick),
        .rst_out     (rst_out),
        .rst_done    (rst_done),
        .rst_cause   (rst_cause)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [2:0] o, input logic d, input logic [1:0] c);
        chk({tag, "_out"}, {5'd0, rst_out}, {5'd0, o});
        chk({tag, "_done"}, {7'd0, rst_done}, {7'd0, d});
        chk({tag, "_cause"}, {6'd0, rst_cause}, {6'd0, c});
    endtask

    // Called right after the reset-event edge E0; bits fall at E0+16/20/24.
    task automatic check_release(input string tag, input logic [1:0] cause);
        for (int n = 1; n <= 24; n++) begin
            tick();
            chk_all(tag, {(n < 24), (n < 20), (n < 16)}, (n >= 24), cause);
        end
    endtask

    initial begin
        // POR
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk_all("por_hold", 3'b111, 1'b0, 2'b01);
        rst = 1'b0;
        check_release("por", 2'b01);

        // soft reset in RUN
        tick();
        tick();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        chk_all("soft_run_evt", 3'b111, 1'b0, 2'b10);
        check_release("soft_run", 2'b10);

        // soft reset mid-RELEASE, 2 cycles after rst_out[0] falls
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        chk_all("mid_rel_bit0", 3'b110, 1'b0, 2'b10);
        tick();
        tick();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        chk_all("mid_rel_evt", 3'b111, 1'b0, 2'b10);
        check_release("mid_rel", 2'b10);

        // watchdog timeout, no kicks
        wdt_en = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk_all("wdt_pre", 3'b000, 1'b1, 2'b10);
        tick();
        chk_all("wdt_evt", 3'b111, 1'b0, 2'b11);
        check_release("wdt", 2'b11);

        // kick every 5 cycles: never times out
        for (int i = 0; i < 40; i++) begin
            wdt_kick = (i % 5 == 4);
            tick();
            chk_all("kick5", 3'b000, 1'b1, 2'b11);
        end
        wdt_kick = 1'b0;

        // kick on the terminal count cycle wins
        for (int i = 0; i < 7; i++) tick();
        wdt_kick = 1'b1;
        tick();
        wdt_kick = 1'b0;
        chk_all("kick_at_7", 3'b000, 1'b1, 2'b11);
        tick();
        chk_all("kick_at_7_after", 3'b000, 1'b1, 2'b11);

        // soft request coincident with timeout: soft wins
        for (int i = 0; i < 6; i++) tick();
        chk_all("soft_wdt_pre", 3'b000, 1'b1, 2'b11);
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        chk_all("soft_wdt_evt", 3'b111, 1'b0, 2'b10);
        wdt_en = 1'b0;

        // rst mid-sequence
        for (int i = 0; i < 18; i++) tick();
        chk_all("rst_mid_pre", 3'b110, 1'b0, 2'b10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all("rst_mid_evt", 3'b111, 1'b0, 2'b01);
        check_release("rst_mid", 2'b01);

        // rst in RUN after a soft-caused sequence
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        check_release("pre_rst_run", 2'b10);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all("rst_run_evt", 3'b111, 1'b0, 2'b01);
        check_release("rst_run", 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
